// File: rtl/cpu_pkg.sv
// Shared CPU core constants: default datapath width, register count and
// the architectural zero register address.
package cpu_pkg;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int AW        = $clog2(NREG);
    localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard. A bit is set at issue and cleared at
// writeback; a set wins over a clear of the same register in one cycle,
// since a new producer issued on the old one's writeback keeps it pending.
// busy_cnt is the registered popcount of the updated vector.
module gpr_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG     = cpu_pkg::NREG,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;

    // Next busy vector: set has priority over clear; zero register never busy
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREG; i++) begin
            if (clr_en && clr_addr == AW'(i))
                busy_nxt[i] = 1'b0;
            if (iss_valid && iss_addr == AW'(i))
                busy_nxt[i] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[ZERO_ADDR] = 1'b0;
    end

    // Popcount of the updated vector, so busy_cnt lines up with busy
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    // Busy state and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// General-purpose register file: NRD combinational read ports, one
// synchronous write port, optional write-to-read bypass, optional
// hard-wired zero register and a busy scoreboard for RAW stalls.
module gpr_file_sb
    import cpu_pkg::*;
#(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int NREG     = cpu_pkg::NREG,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;

    // Writes to the zero register are dropped entirely (no store, no bypass)
    assign wr_ok = we && !((ZERO_REG != 0) && wr_addr == AW'(ZERO_ADDR));

    // Register storage; async reset clears every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    gpr_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .clr_en    (we),
        .clr_addr  (wr_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = rd_addr[k*AW +: AW];

        // Read mux with bypass; bypass is gated by reset so outputs stay 0
        always_comb begin
            d = regs[a];
            if ((BYPASS != 0) && rst_n && wr_ok && a == wr_addr)
                d = wr_data;
            if ((ZERO_REG != 0) && a == AW'(ZERO_ADDR))
                d = '0;
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        // Registered busy only: a same-cycle writeback does not hide it
        assign rd_busy[k] = busy[a];
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb. Two instances share stimulus: dut with
// bypass enabled, dut_nb with bypass disabled.
module tb_gpr_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic [AW:0]         busy_cnt, busy_cnt_nb;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busy_cnt_nb)
    );

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); rd_addr = {5'd5, 5'd3};
        #12;
        vectors++;
        if (rd_data !== 64'h0) begin
            $display("FAIL reset_rd_data got %h want %h", rd_data, 64'h0); errs++;
        end
        vectors++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            $display("FAIL reset_busy got cnt=%0d busy=%b want cnt=0 busy=00", busy_cnt, rd_busy); errs++;
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; rd_addr = {5'd3, 5'd3};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h12345678) begin
            $display("FAIL bypass_same_cycle got %h want %h", rd_data[31:0], 32'h12345678); errs++;
        end
        vectors++;
        if (rd_data_nb[31:0] !== 32'h0) begin
            $display("FAIL nobypass_same_cycle got %h want %h", rd_data_nb[31:0], 32'h0); errs++;
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_data !== {2{32'h12345678}}) begin
            $display("FAIL bypass_next_cycle got %h want %h", rd_data, {2{32'h12345678}}); errs++;
        end
        vectors++;
        if (rd_data_nb[31:0] !== 32'h12345678) begin
            $display("FAIL nobypass_next_cycle got %h want %h", rd_data_nb[31:0], 32'h12345678); errs++;
        end
        vectors++;
        if (busy_cnt !== 6'd0) begin
            $display("FAIL write_nonbusy_cnt got %0d want 0", busy_cnt); errs++;
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
        #1;
        vectors++;
        if (rd_data !== 64'h0) begin
            $display("FAIL zero_no_bypass got %h want 0", rd_data); errs++;
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
            $display("FAIL zero_read got %h/%h want 0", rd_data, rd_data_nb); errs++;
        end
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick(); idle(); #1;
        vectors++;
        if (rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
            $display("FAIL zero_never_busy got busy=%b cnt=%0d want 00/0", rd_busy, busy_cnt); errs++;
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd7, 5'd3};
        iss_valid = 1'b1; iss_addr = 5'd7;
        #1;
        vectors++;
        if (rd_busy !== 2'b00) begin
            $display("FAIL issue_not_yet_busy got %b want 00", rd_busy); errs++;
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_busy !== 2'b10 || busy_cnt !== 6'd1) begin
            $display("FAIL issue_busy got busy=%b cnt=%0d want 10/1", rd_busy, busy_cnt); errs++;
        end
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
        #1;
        vectors++;
        if (rd_busy !== 2'b10 || rd_data[63:32] !== 32'h00000077) begin
            $display("FAIL wb_same_cycle got busy=%b data=%h want 10/00000077", rd_busy, rd_data[63:32]); errs++;
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_busy !== 2'b00 || busy_cnt !== 6'd0 || rd_data[63:32] !== 32'h00000077) begin
            $display("FAIL wb_clear got busy=%b cnt=%0d data=%h want 00/0/00000077",
                     rd_busy, busy_cnt, rd_data[63:32]); errs++;
        end
    endtask

    task automatic test_collision();
        rd_addr = {5'd3, 5'd9};
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick(); idle(); #1;
        vectors++;
        if (rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
            $display("FAIL coll_pre got busy=%b cnt=%0d want 01/1", rd_busy, busy_cnt); errs++;
        end
        iss_valid = 1'b1; iss_addr = 5'd9;
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        tick(); idle(); #1;
        vectors++;
        if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
            $display("FAIL coll_set_wins got data=%h busy=%b cnt=%0d want A5A5A5A5/01/1",
                     rd_data[31:0], rd_busy, busy_cnt); errs++;
        end
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        tick(); idle(); #1;
        vectors++;
        if (busy_cnt !== 6'd0) begin
            $display("FAIL coll_clear got cnt=%0d want 0", busy_cnt); errs++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i < NREG; i++) begin
            iss_valid = 1'b1; iss_addr = AW'(i);
            tick();
            vectors++;
            if (busy_cnt !== 6'(i)) begin
                $display("FAIL sat_fill_%0d got %0d want %0d", i, busy_cnt, i); errs++;
            end
        end
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick(); idle(); tick();
        vectors++;
        if (busy_cnt !== 6'd31) begin
            $display("FAIL sat_hold got %0d want 31", busy_cnt); errs++;
        end
        rd_addr = {5'd31, 5'd1};
        #1;
        vectors++;
        if (rd_busy !== 2'b11) begin
            $display("FAIL sat_busy_ports got %b want 11", rd_busy); errs++;
        end
        for (int i = 1; i < NREG; i++) begin
            we = 1'b1; wr_addr = AW'(i); wr_data = 32'(i);
            tick();
            vectors++;
            if (busy_cnt !== 6'(31 - i)) begin
                $display("FAIL sat_drain_%0d got %0d want %0d", i, busy_cnt, 31 - i); errs++;
            end
        end
        idle(); #1;
        vectors++;
        if (rd_data !== {32'd31, 32'd1} || rd_busy !== 2'b00) begin
            $display("FAIL sat_final got data=%h busy=%b want %h/00", rd_data, rd_busy, {32'd31, 32'd1}); errs++;
        end
    endtask

    task automatic test_reset_mid();
        rd_addr = {5'd5, 5'd5};
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick(); idle(); #1;
        vectors++;
        if (rd_data[31:0] !== 32'hDEADBEEF || busy_cnt !== 6'd1) begin
            $display("FAIL pre_reset got data=%h cnt=%0d want DEADBEEF/1", rd_data[31:0], busy_cnt); errs++;
        end
        #1; rst_n = 1'b0;
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BADF00D;
        #1;
        vectors++;
        if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
            $display("FAIL async_reset_data got %h/%h want 0", rd_data, rd_data_nb); errs++;
        end
        vectors++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            $display("FAIL async_reset_busy got cnt=%0d busy=%b want 0/00", busy_cnt, rd_busy); errs++;
        end
        idle();
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        vectors++;
        if (rd_data !== 64'h0 || busy_cnt !== 6'd0) begin
            $display("FAIL post_reset got data=%h cnt=%0d want 0/0", rd_data, busy_cnt); errs++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
